// File: rtl/inst_rom_loader.sv
// Instruction ROM filled by a little-endian byte stream, then served combinationally to fetch.
// Optional INST_ROM_RELOAD_EN lets a reload_i pulse in RUN return the block to LOAD.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LOAD_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           data_o,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_done_o,
    output logic [DEPTH_LOG2:0]   ld_count_o,
    input  logic                  reload_i
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] LW = CW'(LOAD_WORDS);

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state;
    logic [31:0]   mem [0:(1<<DEPTH_LOG2)-1];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx;
    logic [23:0]   acc;
    logic [31:0]   wdata;
    logic          accept;
    logic          wr_en;
    logic          in_range;

    assign accept  = ld_valid_i & ld_ready_o;
    assign wr_en   = accept & ((idx == 2'd3) | ld_last_i);
    assign cnt_nxt = cnt + 1'b1;

    // Unfilled upper bytes read as zero so a short final word is zero-padded.
    always_comb begin
        wdata = 32'h0;
        case (idx)
            2'd0:    wdata = {24'h0, ld_byte_i};
            2'd1:    wdata = {16'h0, ld_byte_i, acc[7:0]};
            2'd2:    wdata = {8'h0, ld_byte_i, acc[15:0]};
            default: wdata = {ld_byte_i, acc};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            cnt        <= '0;
            idx        <= 2'd0;
            acc        <= 24'h0;
            ld_ready_o <= 1'b1;
            ld_done_o  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (wr_en) begin
                            cnt <= cnt_nxt;
                            idx <= 2'd0;
                            acc <= 24'h0;
                            if (ld_last_i || cnt_nxt == LW) begin
                                state      <= RUN;
                                ld_ready_o <= 1'b0;
                                ld_done_o  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                            acc <= wdata[23:0];
                        end
                    end
                end
                default: begin
`ifdef INST_ROM_RELOAD_EN
                    if (reload_i) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        idx        <= 2'd0;
                        acc        <= 24'h0;
                        ld_ready_o <= 1'b1;
                        ld_done_o  <= 1'b0;
                    end
`endif
                end
            endcase
        end
    end

    // Array has no reset: contents survive reset until overwritten.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[cnt[DEPTH_LOG2-1:0]] <= wdata;
    end

    assign in_range   = (addr_i[31:DEPTH_LOG2+2] == '0);
    assign data_o     = (ce_i && state == RUN && in_range)
                        ? mem[addr_i[DEPTH_LOG2+1:2]] : 32'h0;
    assign ld_count_o = cnt;

`ifdef INST_ROM_RELOAD_EN
    logic unused;
    assign unused = &{1'b0, addr_i[1:0]};
`else
    logic unused;
    assign unused = &{1'b0, addr_i[1:0], reload_i};
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader (LOAD_WORDS=4 to reach the auto-stop).
// Fetch results go through an expected-value scoreboard queue.
module tb_inst_rom_loader;

    localparam int DL = 10;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_o;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_byte_i = 8'h0;
    logic        ld_last_i = 1'b0;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic [DL:0] ld_count_o;
    logic        reload_i = 1'b0;

    inst_rom_loader #(.DEPTH_LOG2(DL), .LOAD_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .data_o(data_o),
        .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ld_ready_o), .ld_done_o(ld_done_o),
        .ld_count_o(ld_count_o), .reload_i(reload_i)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    // Reference model of the array and load pointer
    logic [31:0] model [0:(1<<DL)-1];
    int          mptr;
    int          midx;
    logic [31:0] macc;
    bit          mrun;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", n, act, exp);
        else
            passed++;
    endtask

    task automatic m_reset();
        mptr = 0; midx = 0; macc = 32'h0; mrun = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        @(negedge clk);
        ld_valid_i = 1'b1; ld_byte_i = b; ld_last_i = last;
        @(posedge clk);
        #1;
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        if (!mrun) begin
            macc = macc | (32'(b) << (8 * midx));
            if (midx == 3 || last) begin
                model[mptr] = macc;
                mptr++; midx = 0; macc = 32'h0;
                if (last || mptr == LW) mrun = 1'b1;
            end else begin
                midx++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_count", 32'(ld_count_o), 32'h0);
        chk("rst_done", 32'(ld_done_o), 32'h0);
        chk("rst_ready", 32'(ld_ready_o), 32'h1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fetch(input string n, input logic ce,
                         input logic [31:0] a, input logic [31:0] exp);
        sb_t e;
        @(negedge clk);
        ce_i = ce; addr_i = a;
        sb_q.push_back('{n, exp});
        #1;
        e = sb_q.pop_front();
        chk(e.name, data_o, e.exp);
        ce_i = 1'b0;
    endtask

    function automatic logic [31:0] mfetch(input logic [31:0] a);
        return (mrun && a[31:DL+2] == 0) ? model[a[DL+1:2]] : 32'h0;
    endfunction

    task automatic chk_state(input string n);
        chk({n, "_count"}, 32'(ld_count_o), 32'(mptr));
        chk({n, "_done"}, 32'(ld_done_o), 32'(mrun));
        chk({n, "_ready"}, 32'(ld_ready_o), 32'(!mrun));
    endtask

    vec_t vt[$];

    initial begin
        m_reset();
        ce_i = 1'b1;
        #1;
        chk("rst_data", data_o, 32'h0);
        ce_i = 1'b0;
        do_reset();

        // First word, fetch blocked during LOAD
        send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
        chk("w1_count", 32'(ld_count_o), 32'h1);
        chk("w1_ready", 32'(ld_ready_o), 32'h1);
        fetch("load_fetch", 1'b1, 32'h0, 32'h0);

        send(8'h93, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 1);
        chk("w2_count", 32'(ld_count_o), 32'h2);
        chk("w2_done", 32'(ld_done_o), 32'h1);
        chk("w2_ready", 32'(ld_ready_o), 32'h0);

        vt.push_back('{"f_w0", 1'b1, 32'h0, 32'h00100513});
        vt.push_back('{"f_w1", 1'b1, 32'h4, 32'h00A00593});
        vt.push_back('{"f_mis6", 1'b1, 32'h6, 32'h00A00593});
        vt.push_back('{"f_mis3", 1'b1, 32'h3, 32'h00100513});
        vt.push_back('{"f_ce0", 1'b0, 32'h4, 32'h0});
        vt.push_back('{"f_oor", 1'b1, 32'h00001000, 32'h0});
        vt.push_back('{"f_oor_hi", 1'b1, 32'h80000004, 32'h0});
        foreach (vt[i]) fetch(vt[i].name, vt[i].ce, vt[i].addr, vt[i].exp);

        // Load bytes in RUN are ignored
        send(8'hFF, 0); send(8'hEE, 1);
        chk_state("run_ign");
        fetch("run_ign_f", 1'b1, 32'h4, 32'h00A00593);

        // Short final word, array retained across reset
        do_reset();
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        chk_state("short");
        fetch("short_w0", 1'b1, 32'h0, 32'h00CCBBAA);
        fetch("short_keep", 1'b1, 32'h4, 32'h00A00593);

        // Auto-stop at LOAD_WORDS
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h10 + i), 0);
            if (i == 11) chk_state("auto_mid");
        end
        chk_state("auto_end");
        send(8'h55, 0);
        chk_state("auto_17");
        for (int i = 0; i < LW; i++)
            fetch($sformatf("auto_f%0d", i), 1'b1, 32'(4 * i), mfetch(32'(4 * i)));

        // Reset in the middle of the second word
        do_reset();
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
        send(8'hB1, 0); send(8'hB2, 0);
        chk_state("mid_pre");
        do_reset();
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 1);
        chk_state("reload_w");
        fetch("reload_w0", 1'b1, 32'h0, 32'h12345678);
        fetch("reload_keep", 1'b1, 32'h4, 32'h17161514);

        @(negedge clk);
        reload_i = 1'b1;
        @(posedge clk);
        #1;
        reload_i = 1'b0;
`ifdef INST_ROM_RELOAD_EN
        m_reset();
        chk_state("rl_pulse");
        @(negedge clk);
        reload_i = 1'b1;
        @(posedge clk);
        #1;
        reload_i = 1'b0;
        chk_state("rl_inload");
        send(8'h01, 0); send(8'h02, 1);
        chk_state("rl_done");
        fetch("rl_w0", 1'b1, 32'h0, 32'h00000201);
`else
        chk_state("rl_ignored");
        fetch("rl_ign_w0", 1'b1, 32'h0, 32'h12345678);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
